serializer: RTL and testbench

Parallel-to-serial converter and transmit-side counterpart of the team's deserializer. It accepts a parallel word with a length code and shifts the selected bits out one per clock, MSB (bit `DATA_BUS_WIDTH-1`) first. A per-bit valid qualifies the stream, so a downstream deserializer of the same width rebuilds the word in its original bit order. It sits between the parallel datapath and the serial link.

---
 rtl/serializer_pkg.sv | 11 +
 rtl/serializer.sv | 107 ++++++++++
 tb/tb_serializer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// Shared types and constants for the serializer.
package serializer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam int SER_MIN_LEN = 3;

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial converter, MSB first, with per-bit valid.
// Optional gapless word chaining via SERIALIZER_BACK_TO_BACK_EN.
module serializer
   import serializer_pkg::*;
#(
   parameter int DATA_BUS_WIDTH = 16,
   parameter int MOD_WIDTH      = $clog2(DATA_BUS_WIDTH)
) (
   input  logic                      clk_i,
   input  logic                      arst_n_i,
   input  logic [DATA_BUS_WIDTH-1:0] data_i,
   input  logic [MOD_WIDTH-1:0]      data_mod_i,
   input  logic                      data_val_i,
   output logic                      ready_o,
   output logic                      ser_data_o,
   output logic                      ser_data_val_o,
   output logic                      busy_o
);

   localparam logic [MOD_WIDTH:0] FULL_LEN = (MOD_WIDTH + 1)'(DATA_BUS_WIDTH);
   localparam logic [MOD_WIDTH:0] MIN_LEN  = (MOD_WIDTH + 1)'(SER_MIN_LEN);
   localparam logic [MOD_WIDTH:0] ONE      = (MOD_WIDTH + 1)'(1);

   state_t                    r_state;
   state_t                    w_nextState;
   logic [DATA_BUS_WIDTH-1:0] r_shift;
   logic [MOD_WIDTH:0]        r_cnt;
   logic [MOD_WIDTH:0]        w_len;
   logic                      w_lenOk;
   logic                      w_accept;
   logic                      w_sending;
   logic                      w_lastBit;
   logic                      w_load;

   assign w_len     = (data_mod_i == '0) ? FULL_LEN : {1'b0, data_mod_i};
   assign w_lenOk   = (w_len >= MIN_LEN);
   assign w_sending = (r_state == SEND);
   assign w_lastBit = w_sending && (r_cnt == '0);
   assign w_accept  = data_val_i && ready_o;

`ifdef SERIALIZER_BACK_TO_BACK_EN
   assign ready_o = !w_sending || w_lastBit;
`else
   assign ready_o = !w_sending;
`endif

   // State is a flop, so busy/valid carry no combinational path from inputs.
   assign busy_o         = w_sending;
   assign ser_data_val_o = w_sending;
   assign ser_data_o     = r_shift[DATA_BUS_WIDTH-1] & w_sending;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Short words (len < 3) are consumed by the accept but never loaded.
   always_comb begin
      w_nextState = r_state;
      w_load      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_accept && w_lenOk) begin
               w_nextState = SEND;
               w_load      = 1'b1;
            end
         end
         SEND: begin
            if (w_lastBit) begin
               if (w_accept && w_lenOk) begin
                  w_load = 1'b1;
               end else begin
                  w_nextState = IDLE;
               end
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_shift <= '0;
      end else if (w_load) begin
         r_shift <= data_i;
      end else if (w_sending) begin
         r_shift <= {r_shift[DATA_BUS_WIDTH-2:0], 1'b0};
      end
   end

   // Counter holds bits remaining after the current one; one extra bit fits len = width.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_cnt <= '0;
      end else if (w_load) begin
         r_cnt <= w_len - ONE;
      end else if (w_sending && (r_cnt != '0)) begin
         r_cnt <= r_cnt - ONE;
      end
   end

endmodule

// File: tb/tb_serializer.sv
// Directed, table-driven bench for serializer (16-bit words).
// Expectations adapt to SERIALIZER_BACK_TO_BACK_EN.
module tb_serializer;

   localparam int W  = 16;
   localparam int MW = 4;
`ifdef SERIALIZER_BACK_TO_BACK_EN
   localparam bit BTB = 1'b1;
`else
   localparam bit BTB = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          arst_n_i;
   logic [W-1:0]  data_i;
   logic [MW-1:0] data_mod_i;
   logic          data_val_i;
   logic          ready_o;
   logic          ser_data_o;
   logic          ser_data_val_o;
   logic          busy_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  mod;
      logic [15:0] expBits;
      int          len;
      string       name;
   } vec_t;

   vec_t vecs[7];

   serializer #(
      .DATA_BUS_WIDTH(W),
      .MOD_WIDTH     (MW)
   ) dut (
      .clk_i         (clk_i),
      .arst_n_i      (arst_n_i),
      .data_i        (data_i),
      .data_mod_i    (data_mod_i),
      .data_val_i    (data_val_i),
      .ready_o       (ready_o),
      .ser_data_o    (ser_data_o),
      .ser_data_val_o(ser_data_val_o),
      .busy_o        (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Entered at the negedge of the first bit; returns at the negedge of the last bit.
   task automatic checkWord(input string tag, input logic [15:0] bits, input int len);
      for (int i = 0; i < len; i++) begin
         if (i > 0) @(negedge clk_i);
         checkOutput($sformatf("%s b%0d val", tag, i), ser_data_val_o, 1);
         checkOutput($sformatf("%s b%0d busy", tag, i), busy_o, 1);
         checkOutput($sformatf("%s b%0d data", tag, i), ser_data_o, bits[15-i]);
         checkOutput($sformatf("%s b%0d ready", tag, i), ready_o, (BTB && (i == len - 1)) ? 1 : 0);
      end
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, " idle val"}, ser_data_val_o, 0);
      checkOutput({tag, " idle busy"}, busy_o, 0);
      checkOutput({tag, " idle data"}, ser_data_o, 0);
      checkOutput({tag, " idle ready"}, ready_o, 1);
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clk_i);
      checkOutput({v.name, " ready before"}, ready_o, 1);
      data_i     = v.data;
      data_mod_i = v.mod;
      data_val_i = 1'b1;
      @(negedge clk_i);
      data_val_i = 1'b0;
      if (v.len > 0) begin
         checkWord(v.name, v.expBits, v.len);
         @(negedge clk_i);
      end
      checkIdle(v.name);
      @(negedge clk_i);
      checkIdle({v.name, " +1"});
   endtask

   // Request held high across word 1; word 2 may only enter when ready_o allows it.
   task automatic runPair(input string tag,
                          input logic [15:0] d1, input logic [3:0] m1, input logic [15:0] b1, input int l1,
                          input logic [15:0] d2, input logic [3:0] m2, input logic [15:0] b2, input int l2);
      @(negedge clk_i);
      checkOutput({tag, " ready before"}, ready_o, 1);
      data_i     = d1;
      data_mod_i = m1;
      data_val_i = 1'b1;
      @(negedge clk_i);
      data_i     = d2;
      data_mod_i = m2;
      checkWord({tag, " w1"}, b1, l1);
      if (!BTB) begin
         @(negedge clk_i);
         checkOutput({tag, " gap val"}, ser_data_val_o, 0);
         checkOutput({tag, " gap ready"}, ready_o, 1);
      end
      @(negedge clk_i);
      data_val_i = 1'b0;
      checkWord({tag, " w2"}, b2, l2);
      @(negedge clk_i);
      checkIdle(tag);
   endtask

   initial begin
      vecs[0] = '{16'hA5C3, 4'd0,  16'hA5C3, 16, "full"};
      vecs[1] = '{16'hB00F, 4'd4,  16'hB000, 4,  "partial"};
      vecs[2] = '{16'hFFFF, 4'd1,  16'h0000, 0,  "short1"};
      vecs[3] = '{16'hFFFF, 4'd2,  16'h0000, 0,  "short2"};
      vecs[4] = '{16'h0000, 4'd3,  16'h0000, 3,  "min0"};
      vecs[5] = '{16'h6000, 4'd3,  16'h6000, 3,  "min011"};
      vecs[6] = '{16'h1234, 4'd15, 16'h1234, 15, "len15"};

      arst_n_i   = 1'b0;
      data_i     = '0;
      data_mod_i = '0;
      data_val_i = 1'b0;
      #1;
      checkIdle("reset");
      @(negedge clk_i);
      @(negedge clk_i);
      arst_n_i = 1'b1;

      for (int k = 0; k < 7; k++) begin
         applyStimulus(vecs[k]);
      end

      runPair("busyIgnore", 16'hA5C3, 4'd0, 16'hA5C3, 16, 16'h1234, 4'd0, 16'h1234, 16);
      runPair("b2b", 16'hFFFF, 4'd0, 16'hFFFF, 16, 16'h0000, 4'd3, 16'h0000, 3);

      // Asynchronous abort during bit 5 of A5C3, then a fresh word from its MSB.
      @(negedge clk_i);
      data_i     = 16'hA5C3;
      data_mod_i = 4'd0;
      data_val_i = 1'b1;
      @(negedge clk_i);
      data_val_i = 1'b0;
      repeat (4) @(negedge clk_i);
      checkOutput("rst pre val", ser_data_val_o, 1);
      checkOutput("rst pre data", ser_data_o, 0);
      #2;
      arst_n_i = 1'b0;
      #1;
      checkIdle("rst async");
      @(negedge clk_i);
      checkIdle("rst held");
      arst_n_i = 1'b1;
      applyStimulus('{16'h8001, 4'd0, 16'h8001, 16, "afterRst"});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
